mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle control FSM for the LEGv8 datapath.
- Replaces single-cycle decode with a Moore-style sequencer that steps each instruction through fetch, decode, execute, memory and writeback over 3–5 cycles.
- Shares one unified instruction/data memory through a request/ready handshake, with a wait-state watchdog.
- Sits between the instruction register opcode field (IR[31:21]) and the multicycle datapath muxes and enables.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready before faulting; 0 disables the watchdog
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
Op  in  11  opcode IR[31:21], matched with the shared opcode macros (LDUR, STUR, CBZ, ADD, SUB, AND, ORR, B, BR, ADDI, ANDI, ORRI, SUBI, MOVZ)
Zero  in  1  ALU zero flag, combinational in the current cycle
mem_ready  in  1  memory completes the current read/write this cycle
IRWrite  out  1  load instruction register
PCWrite  out  1  load PC
IorD  out  1  memory address source: 0 = PC, 1 = ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
Reg2Loc  out  1  register read port 2 source: 1 = Rt field
RegWrite  out  1  register file write enable
MemtoReg  out  1  writeback source: 1 = MDR
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = B, 01 = const 4, 10 = sign-extended immediate, 11 = branch offset <<2
ALUOp  out  2  same encoding as the ALU control: 00 add, 01 pass B, 10 R-type funct, 11 I-type funct
PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = register A
instr_done  out  1  one-cycle pulse in the final cycle of each instruction
illegal  out  1  sticky; set on undefined opcode
mem_fault  out  1  sticky; set on watchdog expiry
state_o  out  4  current state, debug

Behaviour:
- State register and wait counter reset synchronously: state ← FETCH, counter ← 0, illegal ← 0, mem_fault ← 0.
- While reset is high, every enable and request (IRWrite, PCWrite, RegWrite, MemRead, MemWrite, instr_done) is forced to 0. Mux selects are 0.
- Any output not listed for a state is 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - mem_ready=1: IRWrite=1, PCWrite=1, go to DECODE.
  - mem_ready=0: stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Reg2Loc=1 for STUR/CBZ. Next state by Op:
  - LDUR/STUR → MEM_ADDR
  - ADD/SUB/AND/ORR → EXEC_R
  - ADDI/ANDI/ORRI/SUBI/MOVZ → EXEC_I
  - CBZ → BR_CBZ
  - B → BR_B
  - BR → BR_REG
  - other → ILLEGAL
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, Reg2Loc=(STUR). Next MEM_RD for LDUR, MEM_WR for STUR.
- MEM_RD: IorD=1, MemRead=1. Go to MEM_WB on mem_ready.
- MEM_WB: RegWrite=1, MemtoReg=1, instr_done=1, go to FETCH.
- MEM_WR: IorD=1, MemWrite=1, Reg2Loc=1. On mem_ready: instr_done=1, go to FETCH.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10, go to ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=11, go to ALU_WB.
- ALU_WB: RegWrite=1, MemtoReg=0, instr_done=1, go to FETCH.
- BR_CBZ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Reg2Loc=1, PCSrc=01, PCWrite=Zero, instr_done=1, go to FETCH.
- BR_B: PCSrc=01, PCWrite=1, instr_done=1, go to FETCH.
- BR_REG: PCSrc=10, PCWrite=1, instr_done=1, go to FETCH.
- ILLEGAL: illegal=1, no enables asserted, held until reset.
- FAULT: mem_fault=1, no enables or requests, held until reset.
- Latency with zero-wait memory (mem_ready high in the request cycle):
  - R-type and I-type: 4 cycles
  - LDUR: 5 cycles
  - STUR: 4 cycles
  - CBZ, B, BR: 3 cycles
  - Each wait cycle adds 1.
- Wait counter:
  - Increments in FETCH, MEM_RD and MEM_WR while mem_ready=0.
  - Clears on any state change.
  - When the counter equals MEM_TIMEOUT with mem_ready still 0 (MEM_TIMEOUT≠0), next state is FAULT and the request drops the following cycle.
  - mem_ready=1 on the timeout cycle wins: normal completion, no fault.
- Request outputs are held stable for the full wait; Op is sampled only in DECODE and MEM_ADDR (IR is stable after FETCH).
- Reset during a wait drops the request in the same cycle; no write completes.

Decomposition:
- Package mc_pkg:
  - state_t enum, logic [3:0], encodings FETCH=0 … FAULT=13
  - ALUSrcB constants and PCSrc constants
  - ALUOp constants
- Opcode patterns stay in the shared macros file.
- One natural sub-module: mc_outdec, a combinational state + Op → control-word decoder.
- mc_control keeps the state register, next-state logic, wait counter and sticky flags.

Test Plan:
- ADDI X1,X31,#5 with mem_ready always 1 → states FETCH, DECODE, EXEC_I, ALU_WB; RegWrite=1 only in cycle 4; instr_done at cycle 4.
- LDUR with mem_ready low for 2 cycles in MEM_RD → MemRead and IorD=1 held for 3 cycles; total 7 cycles; MemtoReg=1 with RegWrite in MEM_WB.
- CBZ with Zero=1, then with Zero=0 → PCWrite=1 with PCSrc=01 in cycle 3; second run PCWrite=0; both take 3 cycles.
- Op=11'h000 (undefined) → ILLEGAL after DECODE; illegal=1 persists; no enables for 10 further cycles; reset returns to FETCH.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH → mem_fault=1 after 5 FETCH cycles; MemRead=0 thereafter. Variant: mem_ready=1 on the 5th cycle → normal DECODE, no fault.
- reset asserted mid-MEM_WR wait → MemWrite=0 in the reset cycle; state_o=FETCH next cycle; instr_done never pulses.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the LEGv8 multicycle controller: state encoding,
// datapath mux codes, opcode classification and the packed control word.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALU_WB   = 4'd8,
    BR_CBZ   = 4'd9,
    BR_B     = 4'd10,
    BR_REG   = 4'd11,
    ILLEGAL  = 4'd12,
    FAULT    = 4'd13
  } state_t;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BROFF  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_REGA   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE = 2'b11;

  typedef enum logic [2:0] {
    OPC_LDUR  = 3'd0,
    OPC_STUR  = 3'd1,
    OPC_RTYPE = 3'd2,
    OPC_ITYPE = 3'd3,
    OPC_CBZ   = 3'd4,
    OPC_B     = 3'd5,
    OPC_BR    = 3'd6,
    OPC_ILL   = 3'd7
  } opclass_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg2loc;
    logic       reg_write;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       instr_done;
  } ctrl_t;

  // Opcode patterns over IR[31:21]; shorter LEGv8 opcodes leave low bits as don't-care.
  function automatic opclass_t op_class(input logic [10:0] op);
    opclass_t c;
    casez (op)
      11'b111_1100_0010: c = OPC_LDUR;
      11'b111_1100_0000: c = OPC_STUR;
      11'b100_0101_1000,
      11'b110_0101_1000,
      11'b100_0101_0000,
      11'b101_0101_0000: c = OPC_RTYPE;
      11'b100_1000_100?,
      11'b100_1001_000?,
      11'b101_1001_000?,
      11'b110_1000_100?,
      11'b110_1001_01??: c = OPC_ITYPE;
      11'b101_1010_0???: c = OPC_CBZ;
      11'b000_101?_????: c = OPC_B;
      11'b110_1011_0000: c = OPC_BR;
      default:           c = OPC_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore-style output decoder: maps the current state (plus Op, Zero and mem_ready
// where a state's outputs depend on them) to the datapath control word.
module mc_outdec
  import mc_pkg::*;
(
  input  state_t      state_i,
  input  logic [10:0] op_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output ctrl_t       ctrl_o
);

  opclass_t opc;

  always_comb begin
    ctrl_o = '0;
    opc    = op_class(op_i);
    case (state_i)
      FETCH: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.alusrcb  = SRCB_FOUR;
        ctrl_o.aluop    = ALUOP_ADD;
        ctrl_o.pcsrc    = PCSRC_ALU;
        ctrl_o.ir_write = mem_ready_i;
        ctrl_o.pc_write = mem_ready_i;
      end
      DECODE: begin
        // Branch target is computed speculatively into ALUOut for every opcode.
        ctrl_o.alusrcb = SRCB_BROFF;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.reg2loc = (opc == OPC_STUR) || (opc == OPC_CBZ);
      end
      MEM_ADDR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.reg2loc = (opc == OPC_STUR);
      end
      MEM_RD: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.mem_read = 1'b1;
      end
      MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.memtoreg   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      MEM_WR: begin
        ctrl_o.iord       = 1'b1;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.reg2loc    = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      EXEC_R: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALUOP_RTYPE;
      end
      EXEC_I: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ITYPE;
      end
      ALU_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      BR_CBZ: begin
        ctrl_o.alusrca    = 1'b1;
        ctrl_o.alusrcb    = SRCB_B;
        ctrl_o.aluop      = ALUOP_PASSB;
        ctrl_o.reg2loc    = 1'b1;
        ctrl_o.pcsrc      = PCSRC_ALUOUT;
        ctrl_o.pc_write   = zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      BR_B: begin
        ctrl_o.pcsrc      = PCSRC_ALUOUT;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      BR_REG: begin
        ctrl_o.pcsrc      = PCSRC_REGA;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// LEGv8 multicycle sequencer: state register, next-state logic, memory wait-state
// watchdog and sticky error flags; outputs come from mc_outdec.
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Reg2Loc,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSrc,
  output logic        instr_done,
  output logic        illegal,
  output logic        mem_fault,
  output logic [3:0]  state_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             fault_q, fault_d;
  logic             waiting, timeout;
  ctrl_t            ctrl_dec, ctrl_out;

  assign waiting = ((state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR))
                   && !mem_ready;
  // A late mem_ready on the timeout cycle still completes normally because waiting is 0.
  assign timeout = waiting && (MEM_TIMEOUT != 0) && (cnt_q == CNT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (op_class(Op))
          OPC_LDUR, OPC_STUR: state_d = MEM_ADDR;
          OPC_RTYPE:          state_d = EXEC_R;
          OPC_ITYPE:          state_d = EXEC_I;
          OPC_CBZ:            state_d = BR_CBZ;
          OPC_B:              state_d = BR_B;
          OPC_BR:             state_d = BR_REG;
          default:            state_d = ILLEGAL;
        endcase
      end
      MEM_ADDR: state_d = (op_class(Op) == OPC_STUR) ? MEM_WR : MEM_RD;
      MEM_RD:   if (mem_ready) state_d = MEM_WB;
      MEM_WB:   state_d = FETCH;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      EXEC_R,
      EXEC_I:   state_d = ALU_WB;
      ALU_WB,
      BR_CBZ,
      BR_B,
      BR_REG:   state_d = FETCH;
      ILLEGAL:  state_d = ILLEGAL;
      FAULT:    state_d = FAULT;
      default:  state_d = FETCH;
    endcase
    if (timeout) state_d = FAULT;
  end

  assign cnt_d     = (waiting && !timeout) ? cnt_q + CNT_W'(1) : '0;
  assign illegal_d = illegal_q || (state_d == ILLEGAL);
  assign fault_d   = fault_q || (state_d == FAULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      fault_q   <= fault_d;
    end
  end

  mc_outdec u_outdec (
    .state_i     (state_q),
    .op_i        (Op),
    .zero_i      (Zero),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_dec)
  );

  // Gating combinationally on reset drops an in-flight request in the reset cycle itself.
  assign ctrl_out = reset ? '0 : ctrl_dec;

  assign IRWrite    = ctrl_out.ir_write;
  assign PCWrite    = ctrl_out.pc_write;
  assign IorD       = ctrl_out.iord;
  assign MemRead    = ctrl_out.mem_read;
  assign MemWrite   = ctrl_out.mem_write;
  assign Reg2Loc    = ctrl_out.reg2loc;
  assign RegWrite   = ctrl_out.reg_write;
  assign MemtoReg   = ctrl_out.memtoreg;
  assign ALUSrcA    = ctrl_out.alusrca;
  assign ALUSrcB    = ctrl_out.alusrcb;
  assign ALUOp      = ctrl_out.aluop;
  assign PCSrc      = ctrl_out.pcsrc;
  assign instr_done = ctrl_out.instr_done;
  assign illegal    = illegal_q;
  assign mem_fault  = fault_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: per-instruction traces, latencies, illegal opcode,
// watchdog expiry and reset during a memory wait, all against hand-computed values.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        reset, Zero, mem_ready;
  logic [10:0] Op;
  logic        IRWrite, PCWrite, IorD, MemRead, MemWrite, Reg2Loc, RegWrite, MemtoReg;
  logic        ALUSrcA, instr_done, illegal, mem_fault;
  logic [1:0]  ALUSrcB, ALUOp, PCSrc;
  logic [3:0]  state_o;

  int checks = 0;
  int errors = 0;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_CBZ  = 11'h5A0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_B    = 11'h0A0;
  localparam logic [10:0] OP_BR   = 11'h6B0;
  localparam logic [10:0] OP_ADDI = 11'h488;
  localparam logic [10:0] OP_MOVZ = 11'h694;

  mc_control #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc),
    .instr_done(instr_done), .illegal(illegal), .mem_fault(mem_fault), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Runs one instruction from FETCH; memory waits apply only to MEM_RD/MEM_WR.
  task automatic run_instr(input logic [10:0] op, input int waits, input logic z,
                           output int n_cyc, output int n_rdio, output int n_wr,
                           output int n_regw, output int n_mtr, output int n_pcw,
                           output int last_pcsrc);
    int   w;
    logic done;
    n_cyc = 0; n_rdio = 0; n_wr = 0; n_regw = 0; n_mtr = 0; n_pcw = 0; last_pcsrc = -1;
    w = 0; done = 1'b0; Op = op; Zero = z;
    for (int i = 0; i < 20 && !done; i++) begin
      if (state_o == 4'd3 || state_o == 4'd5) mem_ready = (w >= waits);
      else mem_ready = 1'b1;
      #1;
      n_cyc++;
      if (MemRead && IorD) n_rdio++;
      if (MemWrite) n_wr++;
      if (RegWrite) n_regw++;
      if (RegWrite && MemtoReg) n_mtr++;
      if (PCWrite) n_pcw++;
      if (instr_done) begin
        done = 1'b1;
        last_pcsrc = int'(PCSrc);
      end
      if ((state_o == 4'd3 || state_o == 4'd5) && !mem_ready) w++;
      tick();
    end
    if (!done) check("instr_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc, rdio, wr, regw, mtr, pcw, pcs, en;
    Op = '0; Zero = 1'b0; mem_ready = 1'b1; reset = 1'b1;

    // Reset state and forced-off outputs while reset is high
    tick(); tick();
    check("rst_irwrite", IRWrite, 0);
    check("rst_memread", MemRead, 0);
    check("rst_pcwrite", PCWrite, 0);
    check("rst_alusrcb", ALUSrcB, 0);
    reset = 1'b0; #1;
    check("rst_state", state_o, 0);
    check("rst_illegal", illegal, 0);
    check("rst_fault", mem_fault, 0);

    // ADDI X1,X31,#5 cycle-by-cycle trace
    Op = OP_ADDI;
    check("addi_c1_state", state_o, 0);
    check("addi_c1_irwrite", IRWrite, 1);
    check("addi_c1_pcwrite", PCWrite, 1);
    check("addi_c1_srcb", ALUSrcB, 1);
    check("addi_c1_regwrite", RegWrite, 0);
    tick();
    check("addi_c2_state", state_o, 1);
    check("addi_c2_srcb", ALUSrcB, 3);
    check("addi_c2_regwrite", RegWrite, 0);
    tick();
    check("addi_c3_state", state_o, 7);
    check("addi_c3_srca", ALUSrcA, 1);
    check("addi_c3_srcb", ALUSrcB, 2);
    check("addi_c3_aluop", ALUOp, 3);
    check("addi_c3_regwrite", RegWrite, 0);
    tick();
    check("addi_c4_state", state_o, 8);
    check("addi_c4_regwrite", RegWrite, 1);
    check("addi_c4_memtoreg", MemtoReg, 0);
    check("addi_c4_done", instr_done, 1);
    tick();
    check("addi_back_fetch", state_o, 0);

    // LDUR with two wait cycles in MEM_RD
    run_instr(OP_LDUR, 2, 1'b0, cyc, rdio, wr, regw, mtr, pcw, pcs);
    check("ldur_cycles", cyc, 7);
    check("ldur_read_held", rdio, 3);
    check("ldur_regwrite", regw, 1);
    check("ldur_memtoreg_wb", mtr, 1);

    run_instr(OP_STUR, 0, 1'b0, cyc, rdio, wr, regw, mtr, pcw, pcs);
    check("stur_cycles", cyc, 4);
    check("stur_write", wr, 1);
    check("stur_no_regwrite", regw, 0);

    run_instr(OP_CBZ, 0, 1'b1, cyc, rdio, wr, regw, mtr, pcw, pcs);
    check("cbz_taken_cycles", cyc, 3);
    check("cbz_taken_pcwrites", pcw, 2);
    check("cbz_taken_pcsrc", pcs, 1);
    run_instr(OP_CBZ, 0, 1'b0, cyc, rdio, wr, regw, mtr, pcw, pcs);
    check("cbz_nt_cycles", cyc, 3);
    check("cbz_nt_pcwrites", pcw, 1);

    run_instr(OP_B, 0, 1'b0, cyc, rdio, wr, regw, mtr, pcw, pcs);
    check("b_cycles", cyc, 3);
    check("b_pcsrc", pcs, 1);
    run_instr(OP_BR, 0, 1'b0, cyc, rdio, wr, regw, mtr, pcw, pcs);
    check("br_cycles", cyc, 3);
    check("br_pcsrc", pcs, 2);
    run_instr(OP_ADD, 0, 1'b0, cyc, rdio, wr, regw, mtr, pcw, pcs);
    check("add_cycles", cyc, 4);
    check("add_regwrite", regw, 1);
    run_instr(OP_MOVZ, 0, 1'b0, cyc, rdio, wr, regw, mtr, pcw, pcs);
    check("movz_cycles", cyc, 4);

    // Undefined opcode locks in ILLEGAL until reset
    Op = 11'h000; mem_ready = 1'b1;
    tick(); tick();
    check("ill_state", state_o, 12);
    check("ill_flag", illegal, 1);
    en = 0;
    for (int i = 0; i < 10; i++) begin
      en += int'(IRWrite) + int'(PCWrite) + int'(RegWrite) + int'(MemRead) +
            int'(MemWrite) + int'(instr_done);
      tick();
    end
    check("ill_no_enables", en, 0);
    check("ill_still_state", state_o, 12);
    check("ill_sticky", illegal, 1);
    do_reset(); #1;
    check("ill_reset_state", state_o, 0);
    check("ill_reset_flag", illegal, 0);

    // Watchdog: mem_ready stuck low in FETCH
    mem_ready = 1'b0; Op = OP_ADD;
    for (int i = 0; i < 5; i++) begin
      check("to_fetch_state", state_o, 0);
      check("to_fetch_memread", MemRead, 1);
      tick();
    end
    check("to_fault_state", state_o, 13);
    check("to_fault_flag", mem_fault, 1);
    check("to_fault_memread", MemRead, 0);
    tick();
    check("to_fault_held", state_o, 13);

    // Same wait, but mem_ready rises on the timeout cycle
    do_reset();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mem_ready = 1'b1; #1;
    check("late_ready_irwrite", IRWrite, 1);
    tick();
    check("late_ready_state", state_o, 1);
    check("late_ready_nofault", mem_fault, 0);
    tick(); tick(); tick();

    // Reset during a MEM_WR wait
    Op = OP_STUR; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0; #1;
    check("wr_wait_state", state_o, 5);
    check("wr_wait_memwrite", MemWrite, 1);
    tick();
    reset = 1'b1; #1;
    check("wr_rst_memwrite", MemWrite, 0);
    check("wr_rst_done", instr_done, 0);
    tick();
    reset = 1'b0; #1;
    check("wr_rst_state", state_o, 0);
    check("wr_rst_done_after", instr_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
